// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_pkg
// Purpose  : Shared types and constants for the SD-card SPI command path.
//            Holds the controller state encoding, the command indices that
//            the controller understands, the R1 status bit positions and the
//            op codes that the SPI slave uses to pick its data direction.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_FETCH  = 3'd2,
        ST_ARM    = 3'd3,
        ST_XFER   = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD1  = 6'd1;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC     = 3;
    localparam int R1_ADDR    = 5;
    localparam int R1_PARAM   = 6;

    // Named from the host's point of view: a host read means the slave sends.
    localparam logic OP_WRITE = 1'b0;  // slave receives from host
    localparam logic OP_READ  = 1'b1;  // slave sends to host

endpackage : sd_pkg
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc7
// Purpose  : Combinational CRC7 (x^7 + x^3 + 1, initial value 0) over the
//            first 40 bits of an SD command frame, MSB first.
// Ports    : data - 40-bit frame prefix (start bits, index, argument)
//            crc  - 7-bit CRC
// Revision : 1.0 - initial release
// ============================================================================
module sd_crc7 (
    input  logic [39:0] data,
    output logic [6:0]  crc
);

    always_comb begin
        logic [6:0] v_crc;
        logic       v_fb;
        v_crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            v_fb  = data[i] ^ v_crc[6];
            v_crc = {v_crc[5:0], 1'b0};
            if (v_fb) begin
                v_crc = v_crc ^ 7'h09;
            end
        end
        crc = v_crc;
    end

endmodule : sd_crc7
`default_nettype wire

// File: rtl/sd_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_controller
// Purpose  : Command sequencer for the SD-card SPI slave. Latches the 6-byte
//            command, validates and decodes it, moves blocks between the
//            shared byte buffer and a backing block store, and drives the
//            slave's op/size/start handshake. Non-data and rejected commands
//            are answered with a single R1 status byte.
// Ports    : clk, rst_n          - clock, async active-low reset
//            cmd[6], transfer    - captured command bytes + receive pulse
//            done                - slave data phase finished
//            op, size, start     - slave data-phase control
//            mem_rdata           - buffer read data
//            slave_data_in       - byte presented to the slave transmitter
//            blk_req/we/addr/ack - block-store handshake
//            in_idle, busy       - status
//            err_count           - saturating count of error responses
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_controller
    import sd_pkg::*;
#(
    parameter  int MEMORY_SIZE_IN_BYTES = 64,
    parameter  int NUM_BLOCKS           = 1024,
    parameter  int CRC_CHECK            = 1,
    localparam int AW                   = $clog2(MEMORY_SIZE_IN_BYTES),
    localparam int BW                   = $clog2(NUM_BLOCKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cmd [0:5],
    input  logic          transfer,
    input  logic          done,
    output logic          op,
    output logic [AW-1:0] size,
    output logic          start,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    slave_data_in,
    output logic          blk_req,
    output logic          blk_we,
    output logic [BW-1:0] blk_addr,
    input  logic          blk_ack,
    output logic          in_idle,
    output logic          busy,
    output logic [7:0]    err_count
);

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_cmd [0:5];
    logic          r_op;
    logic [AW-1:0] r_size;
    logic [BW-1:0] r_blk_addr;
    logic          r_in_idle;
    logic [7:0]    r_err_count;
    logic [AW:0]   r_blocklen;   // one extra bit so the full buffer size fits
    logic          r_rsp_phase;
    logic [7:0]    r_r1;
    logic          r_commit;     // clean CMD24: commit the buffer after XFER

    // ------------------------------------------------------------------
    // Command field extraction and checks on the latched bytes
    // ------------------------------------------------------------------
    logic [31:0] w_arg;
    logic [5:0]  w_idx;
    logic [6:0]  w_crc;
    logic        w_frame_ok;
    logic        w_crc_ok;

    assign w_arg      = {r_cmd[1], r_cmd[2], r_cmd[3], r_cmd[4]};
    assign w_idx      = r_cmd[0][5:0];
    assign w_frame_ok = (r_cmd[0][7:6] == 2'b01) && r_cmd[5][0];
    assign w_crc_ok   = (CRC_CHECK == 0) || (r_cmd[5][7:1] == w_crc);

    sd_crc7 u_crc7 (
        .data ({r_cmd[0], r_cmd[1], r_cmd[2], r_cmd[3], r_cmd[4]}),
        .crc  (w_crc)
    );

    logic          w_in_idle_next;
    logic [AW:0]   w_blocklen_next;
    logic          w_illegal;
    logic          w_crc_err;
    logic          w_addr_err;
    logic          w_param_err;
    logic          w_is_read;
    logic          w_is_write;
    logic [7:0]    w_r1;

    always_comb begin
        w_in_idle_next  = r_in_idle;
        w_blocklen_next = r_blocklen;
        w_illegal       = 1'b0;
        w_crc_err       = 1'b0;
        w_addr_err      = 1'b0;
        w_param_err     = 1'b0;
        w_is_read       = 1'b0;
        w_is_write      = 1'b0;

        // A broken frame or CRC masks every command-specific check.
        if (!w_frame_ok || !w_crc_ok) begin
            w_crc_err = 1'b1;
        end else begin
            case (w_idx)
                CMD0:  w_in_idle_next = 1'b1;
                CMD1:  w_in_idle_next = 1'b0;
                CMD16: begin
                    if ((w_arg != 32'd0) && (w_arg <= 32'(MEMORY_SIZE_IN_BYTES))) begin
                        w_blocklen_next = w_arg[AW:0];
                    end else begin
                        w_param_err = 1'b1;
                    end
                end
                CMD17, CMD24: begin
                    w_illegal  = r_in_idle;
                    // Full 32-bit compare: high argument bits cannot alias.
                    w_addr_err = (w_arg >= 32'(NUM_BLOCKS));
                    if (!r_in_idle && !w_addr_err) begin
                        w_is_read  = (w_idx == CMD17);
                        w_is_write = (w_idx == CMD24);
                    end
                end
                default: w_illegal = 1'b1;
            endcase
        end

        w_r1             = 8'd0;
        w_r1[R1_IDLE]    = w_in_idle_next;
        w_r1[R1_ILLEGAL] = w_illegal;
        w_r1[R1_CRC]     = w_crc_err;
        w_r1[R1_ADDR]    = w_addr_err;
        w_r1[R1_PARAM]   = w_param_err;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (transfer) w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = w_is_read ? ST_FETCH : ST_ARM;
            ST_FETCH:  if (blk_ack) w_state_next = ST_ARM;
            ST_ARM:    w_state_next = ST_XFER;
            ST_XFER:   if (done) w_state_next = r_commit ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: if (blk_ack) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state. blk_req is purely a state decode so
    // an asynchronous reset removes it immediately.
    // ------------------------------------------------------------------
    always_comb begin
        start         = (r_state == ST_ARM);
        busy          = (r_state != ST_IDLE);
        blk_req       = (r_state == ST_FETCH) || (r_state == ST_COMMIT);
        blk_we        = (r_state == ST_COMMIT);
        slave_data_in = r_rsp_phase ? r_r1 : mem_rdata;
    end

    // ------------------------------------------------------------------
    // Datapath: latched command, decode results and persistent flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_cmd[i] <= 8'd0;
            end
            r_op        <= OP_WRITE;
            r_size      <= AW'(MEMORY_SIZE_IN_BYTES - 1);
            r_blk_addr  <= '0;
            r_in_idle   <= 1'b1;
            r_err_count <= 8'd0;
            r_blocklen  <= (AW+1)'(MEMORY_SIZE_IN_BYTES);
            r_rsp_phase <= 1'b0;
            r_r1        <= 8'd0;
            r_commit    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && transfer) begin
                r_cmd <= cmd;
            end

            if (r_state == ST_DECODE) begin
                r_in_idle   <= w_in_idle_next;
                r_blocklen  <= w_blocklen_next;
                r_r1        <= w_r1;
                r_commit    <= w_is_write;
                if (w_is_read || w_is_write) begin
                    r_rsp_phase <= 1'b0;
                    r_op        <= w_is_read ? OP_READ : OP_WRITE;
                    r_size      <= AW'(r_blocklen - (AW+1)'(1));
                    r_blk_addr  <= w_arg[BW-1:0];
                end else begin
                    r_rsp_phase <= 1'b1;
                    r_op        <= OP_READ;
                    r_size      <= '0;
                end
                if ((|w_r1[6:2]) && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end

            // The slave's idle MISO level follows op, so park it on return.
            if ((r_state != ST_IDLE) && (w_state_next == ST_IDLE)) begin
                r_op        <= OP_WRITE;
                r_rsp_phase <= 1'b0;
                r_commit    <= 1'b0;
            end
        end
    end

    assign op        = r_op;
    assign size      = r_size;
    assign blk_addr  = r_blk_addr;
    assign in_idle   = r_in_idle;
    assign err_count = r_err_count;

endmodule : sd_cmd_controller
`default_nettype wire

// File: tb/tb_sd_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_controller
// Purpose  : Scoreboard bench for sd_cmd_controller. The stimulus side
//            evaluates each command against a command-level model of the SD
//            rules and queues the expected slave phase and block-store
//            operation; independent monitors pop and compare whenever the
//            DUT raises start or blk_req. Simple slave and block-store models
//            answer with done / blk_ack after random delays.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_controller;

    localparam int MEM = 64;
    localparam int NB  = 1024;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd [0:5];
    logic       transfer;
    logic       done;
    logic       op;
    logic [5:0] size;
    logic       start;
    logic [7:0] mem_rdata;
    logic [7:0] slave_data_in;
    logic       blk_req;
    logic       blk_we;
    logic [9:0] blk_addr;
    logic       blk_ack;
    logic       in_idle;
    logic       busy;
    logic [7:0] err_count;

    logic done_m, done_s, ack_m, ack_s;
    assign done    = done_m | done_s;
    assign blk_ack = ack_m | ack_s;

    sd_cmd_controller #(
        .MEMORY_SIZE_IN_BYTES (MEM),
        .NUM_BLOCKS           (NB),
        .CRC_CHECK            (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .transfer      (transfer),
        .done          (done),
        .op            (op),
        .size          (size),
        .start         (start),
        .mem_rdata     (mem_rdata),
        .slave_data_in (slave_data_in),
        .blk_req       (blk_req),
        .blk_we        (blk_we),
        .blk_addr      (blk_addr),
        .blk_ack       (blk_ack),
        .in_idle       (in_idle),
        .busy          (busy),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 mem_rdata = 8'($urandom);
    end

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit       op;
        bit [5:0] size;
        bit       rsp;
        bit [7:0] r1;
        bit       lat_chk;
    } exp_t;

    typedef struct {
        bit       we;
        bit [9:0] addr;
    } blk_t;

    exp_t exp_q[$];
    blk_t blk_q[$];

    int tests = 0;
    int fails = 0;
    int t_cyc = 0;
    bit store_hold = 1'b0;

    bit m_idle     = 1'b1;
    int m_blocklen = MEM;
    int m_err      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC7 as polynomial long division of the 40-bit prefix times x^7.
    function automatic bit [6:0] crc7_ref(input bit [39:0] d);
        bit [46:0] r;
        r = {d, 7'd0};
        for (int p = 46; p >= 7; p--) begin
            if (r[p]) r[p -: 8] = r[p -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic bit [47:0] mk_cmd(input bit [5:0] idx, input bit [31:0] arg);
        bit [39:0] d;
        d = {2'b01, idx, arg};
        return {d, crc7_ref(d), 1'b1};
    endfunction

    task automatic send(input bit [47:0] f, input bit wait_idle);
        bit [31:0] arg;
        int        idx;
        bit        ill, ce, ae, pe;
        exp_t      e;
        int        n;
        arg = f[39:8];
        idx = int'(f[45:40]);
        ill = 0; ce = 0; ae = 0; pe = 0;
        e.rsp = 1; e.op = 1; e.size = 6'd0; e.lat_chk = 1;
        if (!(f[47:46] == 2'b01 && f[0] == 1'b1 && f[7:1] == crc7_ref(f[47:8]))) begin
            ce = 1;
        end else begin
            case (idx)
                0:  m_idle = 1'b1;
                1:  m_idle = 1'b0;
                16: if (arg >= 1 && arg <= MEM) m_blocklen = int'(arg); else pe = 1;
                17, 24: begin
                    ill = m_idle;
                    ae  = (arg >= NB);
                    if (!ill && !ae) begin
                        e.rsp     = 0;
                        e.op      = (idx == 17);
                        e.size    = 6'(m_blocklen - 1);
                        e.lat_chk = (idx == 24);
                        blk_q.push_back('{we: (idx == 24), addr: arg[9:0]});
                    end
                end
                default: ill = 1;
            endcase
        end
        e.r1 = {1'b0, pe, ae, 1'b0, ce, ill, 1'b0, m_idle};
        if (e.r1[6:2] != 0 && m_err < 255) m_err++;
        exp_q.push_back(e);

        for (int i = 0; i < 6; i++) cmd[i] = f[47-8*i -: 8];
        transfer = 1'b1;
        t_cyc    = cyc;
        @(negedge clk);
        // Junk bytes and a stray transfer while busy must both be ignored.
        for (int i = 0; i < 6; i++) cmd[i] = 8'($urandom);
        transfer = 1'b1;
        @(negedge clk);
        transfer = 1'b0;

        if (wait_idle) begin
            n = 0;
            while (busy && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) check("idle_timeout", 32'(busy), 32'd0);
            check("in_idle", 32'(in_idle), 32'(m_idle));
            check("err_count", 32'(err_count), 32'(m_err));
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: slave phase launches and block-store requests
    // ------------------------------------------------------------------
    initial begin : mon
        exp_t e;
        blk_t b;
        bit   prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && start) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_start: actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("start_op", 32'(op), 32'(e.op));
                    check("start_size", 32'(size), 32'(e.size));
                    if (e.rsp) check("r1", 32'(slave_data_in), 32'(e.r1));
                    else       check("data_mux", 32'(slave_data_in), 32'(mem_rdata));
                    // start in the third cycle, counting the transfer cycle as the first
                    if (e.lat_chk) check("latency", 32'(cyc - t_cyc + 1), 32'd3);
                end
            end
            if (rst_n && blk_req && !prev_req) begin
                if (blk_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_blk_req: actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    b = blk_q.pop_front();
                    check("blk_we", 32'(blk_we), 32'(b.we));
                    check("blk_addr", 32'(blk_addr), 32'(b.addr));
                end
            end
            prev_req = blk_req;
        end
    end

    // Slave model: finishes the data phase a few cycles after start.
    initial begin : slave_model
        bit       o;
        bit [5:0] s;
        done_m = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && start) begin
                o = op;
                s = size;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                check("op_stable", 32'(op), 32'(o));
                check("size_stable", 32'(size), 32'(s));
                done_m = 1'b1;
                @(negedge clk);
                done_m = 1'b0;
                check("op_idle", 32'(op), 32'(blk_req ? 1'b0 : 1'b0) | 32'(busy & op));
            end
        end
    end

    // Block-store model: acknowledges a request after a random wait.
    initial begin : store_model
        ack_m = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && blk_req && !store_hold) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                ack_m = 1'b1;
                @(negedge clk);
                ack_m = 1'b0;
                check("blk_req_drop", 32'(blk_req), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic check_reset_values();
        check("rst_op", 32'(op), 32'd0);
        check("rst_size", 32'(size), 32'(MEM - 1));
        check("rst_start", 32'(start), 32'd0);
        check("rst_blk_req", 32'(blk_req), 32'd0);
        check("rst_blk_we", 32'(blk_we), 32'd0);
        check("rst_blk_addr", 32'(blk_addr), 32'd0);
        check("rst_in_idle", 32'(in_idle), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
    endtask

    initial begin : stim
        bit [47:0] f;
        bit [5:0]  idx;
        bit [31:0] arg;
        int        r, n;

        rst_n = 1'b0;
        transfer = 1'b0;
        done_s = 1'b0;
        ack_s = 1'b0;
        for (int i = 0; i < 6; i++) cmd[i] = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        // Stray done / blk_ack while idle
        done_s = 1'b1; ack_s = 1'b1;
        @(negedge clk);
        done_s = 1'b0; ack_s = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_blk_req", 32'(blk_req), 32'd0);

        send(48'h40_00_00_00_00_95, 1);    // CMD0 -> 0x01
        send(mk_cmd(6'd17, 32'd0), 1);     // illegal while idle -> 0x05
        send(48'h41_00_00_00_00_F9, 1);    // CMD1 -> 0x00
        send(mk_cmd(6'd17, 32'd5), 1);     // fetch block 5, send 64 bytes
        check("op_after_read", 32'(op), 32'd0);
        send(mk_cmd(6'd24, 32'd7), 1);     // receive 64 bytes, commit block 7
        send(mk_cmd(6'd16, 32'd16), 1);
        send(mk_cmd(6'd17, 32'd3), 1);     // size 15
        send(mk_cmd(6'd16, 32'd0), 1);     // 0x40, blocklen unchanged
        send(mk_cmd(6'd24, 32'd2), 1);     // still size 15
        send(mk_cmd(6'd17, 32'd1024), 1);  // 0x20
        send(mk_cmd(6'd17, 32'h8000_0005), 1);
        send(mk_cmd(6'd16, 32'd64), 1);
        send(mk_cmd(6'd1, 32'd0) ^ 48'h2, 1);          // CRC corrupted -> 0x08
        send(mk_cmd(6'd0, 32'd0) | 48'hC000_0000_0000, 1);  // bad start bits
        send(mk_cmd(6'd0, 32'd0) & ~48'h1, 1);         // bad end bit
        send(mk_cmd(6'd55, 32'd0), 1);                 // unknown index

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       idx = 6'd0;
                1, 9:    idx = 6'd1;
                2, 3:    idx = 6'd16;
                4, 5:    idx = 6'd17;
                6, 7:    idx = 6'd24;
                default: idx = 6'($urandom);
            endcase
            if (idx == 6'd16)      arg = 32'($urandom_range(0, 70));
            else if ($urandom_range(0, 9) == 0) arg = $urandom;
            else                   arg = 32'($urandom_range(0, 1030));
            f = mk_cmd(idx, arg);
            if ($urandom_range(0, 9) == 0) f = f ^ (48'h2 << $urandom_range(0, 6));
            send(f, 1);
        end

        // Reset while waiting for the block store
        send(mk_cmd(6'd1, 32'd0), 1);
        store_hold = 1'b1;
        send(mk_cmd(6'd17, 32'd9), 0);
        n = 0;
        while (!blk_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", 32'(blk_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        exp_q.delete();
        blk_q.delete();
        m_idle = 1'b1; m_blocklen = MEM; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        store_hold = 1'b0;
        @(negedge clk);
        send(48'h41_00_00_00_00_F9, 1);
        send(mk_cmd(6'd24, 32'd11), 1);   // blocklen back to 64 after reset

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("blk_q_drained", 32'(blk_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sd_cmd_controller
`default_nettype wire

// File: doc/sd_cmd_controller.md
# sd_cmd_controller

Command sequencer for the SD-card SPI slave. It latches the 6-byte command the slave captures and decodes it. It then drives the slave's `op`/`size`/`start` handshake and moves 512-byte-style blocks between the shared byte buffer and a backing block store. Non-data and rejected commands are answered with a single R1 status byte, which the block muxes onto the slave's transmit data path.

## Interface
- `MEMORY_SIZE_IN_BYTES`, default 64: buffer size, which is also the maximum block length.
- `NUM_BLOCKS`, default 1024: number of addressable blocks in the backing store.
- `CRC_CHECK`, default 1: when 1, the CRC7 field is enforced; when 0, it is ignored.
- `AW` = $clog2(MEMORY_SIZE_IN_BYTES), `BW` = $clog2(NUM_BLOCKS): derived localparams.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd[6]` in 8 each: command bytes from the slave. They are valid in the `transfer` cycle.
- `transfer` in 1: one-cycle pulse indicating a command was received.
- `done` in 1: one-cycle pulse indicating the slave data phase has finished.
- `op` out 1: 0 = slave receives from host, 1 = slave sends to host.
- `size` out AW: index of the last byte of the phase (bytes transferred = size+1).
- `start` out 1: one-cycle pulse that launches the slave data phase.
- `mem_rdata` in 8: buffer read data.
- `slave_data_in` out 8: data the slave transmits; equals `r1` during a response phase, otherwise `mem_rdata`.
- `blk_req` out 1: block-store request, level.
- `blk_we` out 1: 1 = commit buffer to store, 0 = fetch store into buffer.
- `blk_addr` out BW: block index.
- `blk_ack` in 1: one-cycle completion pulse from the block store.
- `in_idle` out 1: SD idle-state flag.
- `busy` out 1: high in any state other than IDLE.
- `err_count` out 8: saturating count of responses with any error bit set.

## Operation
Command checks on the latched bytes:
- `cmd[0][7:6]` must be `01`.
- Command index = `cmd[0][5:0]`.
- Argument = {`cmd[1]`,`cmd[2]`,`cmd[3]`,`cmd[4]`}.
- `cmd[5][0]` must be 1.
- When `CRC_CHECK` = 1, `cmd[5][7:1]` must equal the CRC7 (x^7+x^3+1, init 0) of the first 40 bits.

R1 byte bits: bit0 = `in_idle`, bit2 = illegal command, bit3 = CRC error, bit5 = address error, bit6 = parameter error. All other bits are 0.

Error precedence: a framing error (bad start or end bit) or a CRC error yields CRC error only. Otherwise, command-specific checks apply.

Commands:
- **CMD0**: sets `in_idle`. Responds R1.
- **CMD1**: clears `in_idle`. Responds R1.
- **CMD16**: if 1 ≤ arg ≤ MEMORY_SIZE_IN_BYTES, sets `blocklen` = arg. Otherwise sets parameter error and leaves `blocklen` unchanged. Responds R1.
- **CMD17**: illegal if `in_idle`. Address error if arg ≥ NUM_BLOCKS. If clean: FETCH the block, then send with `op`=1, `size`=`blocklen`-1.
- **CMD24**: same legality checks as CMD17. If clean: receive with `op`=0, `size`=`blocklen`-1, then COMMIT the block.
- **Any other index**: illegal command. Responds R1.

Every R1 response is sent with `op`=1, `size`=0, and `slave_data_in`=`r1`.

State machine (IDLE, DECODE, FETCH, ARM, XFER, COMMIT):
- **IDLE**: `transfer` latches `cmd` and moves to DECODE.
- **DECODE** (1 cycle): computes `r1`, `rsp_phase`, `op`, `size`, and `blk_addr`.
  - A clean CMD17 goes to FETCH.
  - Everything else goes to ARM.
- **FETCH**: holds `blk_req`=1 with `blk_we`=0. On `blk_ack`, goes to ARM.
- **ARM** (1 cycle): pulses `start`, then goes to XFER.
- **XFER**: waits for `done`.
  - For a clean CMD24, goes to COMMIT.
  - Otherwise, goes to IDLE.
- **COMMIT**: holds `blk_req`=1 with `blk_we`=1. On `blk_ack`, goes to IDLE.

Side effects of the latched flags:
- `in_idle` and `blocklen` update in DECODE.
- `err_count` increments in DECODE when `r1[6:2]` ≠ 0, saturating at 255.

## Timing
Reset values:
- `op`=0, `size`=MEMORY_SIZE_IN_BYTES-1, `start`=0.
- `blk_req`=0, `blk_we`=0, `blk_addr`=0.
- `in_idle`=1, `busy`=0, `err_count`=0.
- `blocklen`=MEMORY_SIZE_IN_BYTES; `rsp_phase`=0.

Latency and handshakes:
- `transfer` to `start` is 3 cycles when no FETCH is needed (IDLE→DECODE→ARM, with `start` asserted in ARM's cycle).
- With a FETCH, the latency grows by the cycles spent waiting for `blk_ack`.
- `op` and `size` are stable from DECODE through XFER. `op` returns to 0 when the block re-enters IDLE, because the slave's idle MISO depends on `op`.
- `blk_req` rises on FETCH or COMMIT entry and drops in the cycle after `blk_ack`. `blk_addr` and `blk_we` are stable while `blk_req` is high.
- `blk_ack` while `blk_req`=0 is ignored.

Boundary conditions:
- `transfer` outside IDLE is ignored, since the slave cannot issue one then.
- `done` outside XFER is ignored.
- `size` = `blocklen`-1 truncated to AW bits; `blocklen`=MEMORY_SIZE_IN_BYTES gives all ones.
- The arg comparison uses the full 32 bits, so arg ≥ 2^BW is an address error.
- Reset mid-operation returns everything to the reset values immediately, and `blk_req` drops asynchronously.

## Structure
- Package `sd_pkg` holds:
  - the state enum;
  - command index constants (CMD0, CMD1, CMD16, CMD17, CMD24);
  - R1 bit-position constants;
  - the `OP_READ`/`OP_WRITE` constants shared with the SPI slave.
- Sub-module `sd_crc7` is a combinational CRC7 over a 40-bit input.

## Test plan
- Reset, then CMD0 `40 00 00 00 00 95`:
  - Before the command: `in_idle`=1, `size`=63.
  - Response: `start` 3 cycles after `transfer`, `op`=1, `size`=0, `slave_data_in`=0x01.
- CMD17 with a valid CRC while `in_idle`: R1=0x05, no `blk_req`, `err_count`=1.
- CMD1 `41 00 00 00 00 F9`, then CMD17 arg 5:
  - CMD1 yields R1=0x00.
  - CMD17 yields `blk_req`=1, `blk_we`=0, `blk_addr`=5.
  - With `blk_ack` 4 cycles later: `start` with `op`=1, `size`=63; after `done`, back to IDLE with `op`=0.
- CMD24 arg 7 (after CMD1): `start` with `op`=0, `size`=63; after `done`, `blk_req`=1, `blk_we`=1, `blk_addr`=7; after `blk_ack`, `busy`=0.
- CMD16 arg 16 → R1 0x00, and the next CMD17 uses `size`=15. CMD16 arg 0 → R1 0x40, `blocklen` unchanged. CMD17 arg 1024 → R1 0x20.
- Corrupted CRC byte → R1 0x08. Asserting `rst_n` low during FETCH drops `blk_req` at once and restores all reset values.
